// File: rtl/cfar_threshold_apply.sv
// Captures one threshold per RDM row from the histogram block, then replays the
// amplitude stream and flags every cell whose amplitude strictly exceeds its row threshold.
module cfar_threshold_apply #(
  parameter  int NUM_ROWS = 2048,
  parameter  int ROW_LEN  = 64,
  parameter  int AMP_W    = 32,
  parameter  int TH_W     = 16,
  localparam int RA       = $clog2(NUM_ROWS),
  localparam int CA       = $clog2(ROW_LEN)
) (
  input  logic             clk_100mhz,
  input  logic             reset_n,
  input  logic             th_vld_i,
  input  logic [TH_W-1:0]  th_data_i,
  input  logic             hist_busy_i,
  input  logic             rdm_tvalid_i,
  input  logic [AMP_W-1:0] rdm_tdata_i,
  input  logic             rdm_tlast_i,
  output logic             rdm_tready_o,
  output logic             det_valid_o,
  output logic [AMP_W-1:0] det_amp_o,
  output logic [RA-1:0]    det_row_o,
  output logic [CA-1:0]    det_col_o,
  output logic             frame_done_o,
  output logic             th_overflow_o,
  output logic             row_len_err_o
);

  localparam logic [RA:0]   WR_FULL  = (RA+1)'(NUM_ROWS);
  localparam logic [RA-1:0] ROW_MAX  = RA'(NUM_ROWS - 1);
  localparam logic [CA-1:0] COL_LAST = CA'(ROW_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PREFETCH,
    S_ARM,
    S_SCAN,
    S_RELOAD,
    S_REFILL,
    S_DONE
  } state_t;

  state_t            state;
  logic [RA:0]       wr_addr;
  logic [RA-1:0]     rd_addr;
  logic [RA-1:0]     row;
  logic [CA-1:0]     col;
  logic [TH_W-1:0]   th_cur;
  logic [TH_W-1:0]   rd_data;
  logic [TH_W-1:0]   th_mem [NUM_ROWS];

  logic              ram_we;
  logic [RA-1:0]     ram_waddr;
  logic              beat;

  logic              s1_vld;
  logic [AMP_W-1:0]  s1_amp;
  logic [TH_W-1:0]   s1_th;
  logic [RA-1:0]     s1_row;
  logic [CA-1:0]     s1_col;
  logic              s1_hit;

  assign beat      = rdm_tvalid_i & rdm_tready_o;
  assign ram_we    = th_vld_i & ((state == S_IDLE) | ((state == S_LOAD) & (wr_addr != WR_FULL)));
  assign ram_waddr = (state == S_IDLE) ? '0 : wr_addr[RA-1:0];
  assign s1_hit    = s1_amp > AMP_W'(s1_th);

  // Threshold store: no reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge clk_100mhz) begin
    if (ram_we) begin
      th_mem[ram_waddr] <= th_data_i;
    end
    rd_data <= th_mem[rd_addr];
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      wr_addr       <= '0;
      rd_addr       <= '0;
      row           <= '0;
      col           <= '0;
      th_cur        <= '0;
      rdm_tready_o  <= 1'b0;
      frame_done_o  <= 1'b0;
      th_overflow_o <= 1'b0;
      row_len_err_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (th_vld_i && (state != S_IDLE) && (state != S_LOAD)) begin
        th_overflow_o <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (th_vld_i) begin
            wr_addr       <= (RA+1)'(1);
            th_overflow_o <= 1'b0;
            row_len_err_o <= 1'b0;
            state         <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (th_vld_i) begin
            if (wr_addr == WR_FULL) begin
              th_overflow_o <= 1'b1;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
          if ((wr_addr == WR_FULL) && !hist_busy_i) begin
            rd_addr <= '0;
            state   <= S_PREFETCH;
          end
        end
        S_PREFETCH: state <= S_ARM;
        S_ARM: begin
          th_cur       <= rd_data;
          row          <= '0;
          col          <= '0;
          rdm_tready_o <= 1'b1;
          state        <= S_SCAN;
        end
        S_SCAN: begin
          if (beat) begin
            if (rdm_tlast_i) begin
              // A short row is flagged but still closes the row, keeping row indices in step.
              col          <= '0;
              rdm_tready_o <= 1'b0;
              if (col != COL_LAST) begin
                row_len_err_o <= 1'b1;
              end
              if (row == ROW_MAX) begin
                frame_done_o <= 1'b1;
                state        <= S_DONE;
              end else begin
                row     <= row + 1'b1;
                rd_addr <= row + 1'b1;
                state   <= S_RELOAD;
              end
            end else if (col == COL_LAST) begin
              col           <= '0;
              row_len_err_o <= 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_RELOAD: state <= S_REFILL;
        S_REFILL: begin
          th_cur       <= rd_data;
          rdm_tready_o <= 1'b1;
          state        <= S_SCAN;
        end
        S_DONE: begin
          wr_addr <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The row threshold travels with the beat, so a reload right after tlast cannot affect it.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld      <= 1'b0;
      s1_amp      <= '0;
      s1_th       <= '0;
      s1_row      <= '0;
      s1_col      <= '0;
      det_valid_o <= 1'b0;
      det_amp_o   <= '0;
      det_row_o   <= '0;
      det_col_o   <= '0;
    end else begin
      s1_vld <= beat;
      if (beat) begin
        s1_amp <= rdm_tdata_i;
        s1_th  <= th_cur;
        s1_row <= row;
        s1_col <= col;
      end
      det_valid_o <= s1_vld & s1_hit;
      if (s1_vld && s1_hit) begin
        det_amp_o <= s1_amp;
        det_row_o <= s1_row;
        det_col_o <= s1_col;
      end
    end
  end

endmodule

// File: tb/tb_cfar_threshold_apply.sv
// Directed bench for cfar_threshold_apply: a frame-level model predicts every detection,
// frame_done pulse and row-change ready gap; literal expectations pin each scenario.
module tb_cfar_threshold_apply;

  localparam int NUM_ROWS = 4;
  localparam int ROW_LEN  = 8;
  localparam int AMP_W    = 32;
  localparam int TH_W     = 16;
  localparam int RA       = 2;
  localparam int CA       = 3;

  logic             clk_100mhz = 1'b0;
  logic             reset_n    = 1'b0;
  logic             th_vld_i   = 1'b0;
  logic [TH_W-1:0]  th_data_i  = '0;
  logic             hist_busy_i  = 1'b0;
  logic             rdm_tvalid_i = 1'b0;
  logic [AMP_W-1:0] rdm_tdata_i  = '0;
  logic             rdm_tlast_i  = 1'b0;
  logic             rdm_tready_o;
  logic             det_valid_o;
  logic [AMP_W-1:0] det_amp_o;
  logic [RA-1:0]    det_row_o;
  logic [CA-1:0]    det_col_o;
  logic             frame_done_o;
  logic             th_overflow_o;
  logic             row_len_err_o;

  always #5 clk_100mhz = ~clk_100mhz;

  cfar_threshold_apply #(
    .NUM_ROWS(NUM_ROWS),
    .ROW_LEN (ROW_LEN),
    .AMP_W   (AMP_W),
    .TH_W    (TH_W)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .reset_n      (reset_n),
    .th_vld_i     (th_vld_i),
    .th_data_i    (th_data_i),
    .hist_busy_i  (hist_busy_i),
    .rdm_tvalid_i (rdm_tvalid_i),
    .rdm_tdata_i  (rdm_tdata_i),
    .rdm_tlast_i  (rdm_tlast_i),
    .rdm_tready_o (rdm_tready_o),
    .det_valid_o  (det_valid_o),
    .det_amp_o    (det_amp_o),
    .det_row_o    (det_row_o),
    .det_col_o    (det_col_o),
    .frame_done_o (frame_done_o),
    .th_overflow_o(th_overflow_o),
    .row_len_err_o(row_len_err_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] amp;
    int          row;
    int          col;
  } det_t;

  det_t        exp_q[$];
  logic [15:0] th_model [NUM_ROWS];
  logic [15:0] th_vec [NUM_ROWS];
  int          m_row = 0;
  int          m_col = 0;
  int          edge_cnt = 0;
  int          done_due = -1;
  int          gap_base = -100;
  bit          gap_reopen = 1'b0;

  // Frame model: tracks the stream position and predicts outputs per accepted beat.
  always @(posedge clk_100mhz) begin
    edge_cnt++;
    if (!reset_n) begin
      exp_q.delete();
      m_row    = 0;
      m_col    = 0;
      done_due = -1;
      gap_base = -100;
    end else if (rdm_tvalid_i && rdm_tready_o) begin
      if (rdm_tdata_i > {16'h0, th_model[m_row]}) begin
        exp_q.push_back('{edge_cnt + 1, rdm_tdata_i, m_row, m_col});
      end
      if (rdm_tlast_i) begin
        m_col    = 0;
        gap_base = edge_cnt;
        if (m_row == NUM_ROWS - 1) begin
          m_row      = 0;
          done_due   = edge_cnt;
          gap_reopen = 1'b0;
        end else begin
          m_row++;
          gap_reopen = 1'b1;
        end
      end else if (m_col == ROW_LEN - 1) begin
        m_col = 0;
      end else begin
        m_col++;
      end
    end
  end

  int          det_cnt = 0;
  int          fd_cnt = 0;
  bit          first_seen = 1'b0;
  logic [31:0] first_amp, last_amp;
  int          first_row, first_col, last_row, last_col;

  always @(negedge clk_100mhz) begin
    if (reset_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
        check_output("det_valid", 64'(det_valid_o), 64'd1);
        check_output("det_amp", 64'(det_amp_o), 64'(exp_q[0].amp));
        check_output("det_row", 64'(det_row_o), 64'(exp_q[0].row));
        check_output("det_col", 64'(det_col_o), 64'(exp_q[0].col));
        void'(exp_q.pop_front());
      end else begin
        check_output("det_valid_quiet", 64'(det_valid_o), 64'd0);
      end
      check_output("frame_done", 64'(frame_done_o), 64'(done_due == edge_cnt));
      if (edge_cnt == gap_base || edge_cnt == gap_base + 1) begin
        check_output("tready_gap", 64'(rdm_tready_o), 64'd0);
      end else if (edge_cnt == gap_base + 2 && gap_reopen) begin
        check_output("tready_reopen", 64'(rdm_tready_o), 64'd1);
      end
      if (det_valid_o) begin
        det_cnt++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_amp  = det_amp_o;
          first_row  = int'(det_row_o);
          first_col  = int'(det_col_o);
        end
        last_amp = det_amp_o;
        last_row = int'(det_row_o);
        last_col = int'(det_col_o);
      end
      if (frame_done_o) fd_cnt++;
    end
  end

  function automatic logic [31:0] amp_for(input int test, input int r, input int c);
    case (test)
      1: return 32'(50 * (c + 1) * (r + 1));
      2: begin
        if (r == 0 && c == 0) return 32'h0FF;
        if (r == 0 && c == 1) return 32'h100;
        if (r == 0 && c == 2) return 32'h101;
        return 32'h0;
      end
      3: return 32'(c);
      4: return 32'd25;
      default: return 32'd1;
    endcase
  endfunction

  task automatic set_th(input int a, input int b, input int c, input int d);
    th_vec[0] = 16'(a);
    th_vec[1] = 16'(b);
    th_vec[2] = 16'(c);
    th_vec[3] = 16'(d);
  endtask

  task automatic load_thresholds();
    for (int i = 0; i < NUM_ROWS; i++) begin
      th_vld_i    = 1'b1;
      th_data_i   = th_vec[i];
      th_model[i] = th_vec[i];
      @(negedge clk_100mhz);
    end
    th_vld_i = 1'b0;
  endtask

  task automatic stray_threshold(input logic [15:0] value);
    th_vld_i  = 1'b1;
    th_data_i = value;
    @(negedge clk_100mhz);
    th_vld_i = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] amp, input logic last);
    int guard = 0;
    rdm_tvalid_i = 1'b1;
    rdm_tdata_i  = amp;
    rdm_tlast_i  = last;
    while (rdm_tready_o !== 1'b1 && guard < 200) begin
      @(negedge clk_100mhz);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL beat_timeout: tready stayed 0 for %0d cycles, expected 1", guard);
    end
    @(negedge clk_100mhz);
    rdm_tvalid_i = 1'b0;
    rdm_tlast_i  = 1'b0;
  endtask

  task automatic send_rows(input int test, input int first_r, input int last_r);
    for (int r = first_r; r <= last_r; r++) begin
      for (int c = 0; c < ROW_LEN; c++) begin
        send_beat(amp_for(test, r, c), c == ROW_LEN - 1);
      end
    end
  endtask

  task automatic start_test();
    det_cnt    = 0;
    fd_cnt     = 0;
    first_seen = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk_100mhz);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_tready"}, 64'(rdm_tready_o), 64'd0);
    check_output({tag, "_det_valid"}, 64'(det_valid_o), 64'd0);
    check_output({tag, "_det_amp"}, 64'(det_amp_o), 64'd0);
    check_output({tag, "_det_row"}, 64'(det_row_o), 64'd0);
    check_output({tag, "_det_col"}, 64'(det_col_o), 64'd0);
    check_output({tag, "_frame_done"}, 64'(frame_done_o), 64'd0);
    check_output({tag, "_overflow"}, 64'(th_overflow_o), 64'd0);
    check_output({tag, "_len_err"}, 64'(row_len_err_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ready_high;
    int lat;

    repeat (3) @(negedge clk_100mhz);
    check_all_zero("reset");
    #3 reset_n = 1'b1;
    @(negedge clk_100mhz);

    // Normal frame: row r thresholds 100*(r+1), cells 50*(col+1)*(r+1).
    start_test();
    set_th(100, 200, 300, 400);
    load_thresholds();
    send_rows(1, 0, NUM_ROWS - 1);
    drain();
    check_output("t1_det_count", 64'(det_cnt), 64'd24);
    check_output("t1_first_amp", 64'(first_amp), 64'd150);
    check_output("t1_first_row", 64'(first_row), 64'd0);
    check_output("t1_first_col", 64'(first_col), 64'd2);
    check_output("t1_frame_done_pulses", 64'(fd_cnt), 64'd1);
    check_output("t1_overflow", 64'(th_overflow_o), 64'd0);
    check_output("t1_len_err", 64'(row_len_err_o), 64'd0);

    // Equality boundary: only 0x101 exceeds 0x100.
    start_test();
    set_th(16'h100, 16'h100, 16'h100, 16'h100);
    load_thresholds();
    send_rows(2, 0, NUM_ROWS - 1);
    drain();
    check_output("t2_det_count", 64'(det_cnt), 64'd1);
    check_output("t2_amp", 64'(last_amp), 64'h101);
    check_output("t2_row", 64'(last_row), 64'd0);
    check_output("t2_col", 64'(last_col), 64'd2);

    // Busy hold, then a stray threshold during SCAN that must not reach the RAM.
    start_test();
    hist_busy_i = 1'b1;
    set_th(5, 6, 7, 8);
    load_thresholds();
    ready_high = 0;
    repeat (20) begin
      @(negedge clk_100mhz);
      if (rdm_tready_o) ready_high++;
    end
    check_output("t3_ready_while_busy", 64'(ready_high), 64'd0);
    hist_busy_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_100mhz);
      lat++;
    end while (!rdm_tready_o && lat < 10);
    check_output("t3_ready_latency", 64'(lat), 64'd3);
    check_output("t3_overflow_before", 64'(th_overflow_o), 64'd0);
    stray_threshold(16'h0000);
    check_output("t3_overflow_scan", 64'(th_overflow_o), 64'd1);
    send_rows(3, 0, NUM_ROWS - 1);
    drain();
    check_output("t3_det_count", 64'(det_cnt), 64'd3);

    // Overflow: fifth threshold in LOAD, then another during SCAN.
    start_test();
    hist_busy_i = 1'b1;
    set_th(10, 20, 30, 40);
    load_thresholds();
    check_output("t4_overflow_cleared", 64'(th_overflow_o), 64'd0);
    stray_threshold(16'd99);
    check_output("t4_overflow_load", 64'(th_overflow_o), 64'd1);
    hist_busy_i = 1'b0;
    send_rows(4, 0, 0);
    stray_threshold(16'd99);
    send_rows(4, 1, NUM_ROWS - 1);
    drain();
    check_output("t4_det_count", 64'(det_cnt), 64'd16);
    check_output("t4_overflow_end", 64'(th_overflow_o), 64'd1);

    // Short row 1 (tlast on col 5) and a column wrap without tlast in row 3.
    start_test();
    set_th(0, 0, 0, 0);
    load_thresholds();
    check_output("t5_overflow_cleared", 64'(th_overflow_o), 64'd0);
    send_rows(5, 0, 0);
    check_output("t5_len_err_clean", 64'(row_len_err_o), 64'd0);
    for (int c = 0; c < 6; c++) send_beat(32'd1, c == 5);
    check_output("t5_len_err_short", 64'(row_len_err_o), 64'd1);
    send_rows(5, 2, 2);
    for (int c = 0; c < 2 * ROW_LEN; c++) send_beat(32'd1, c == 2 * ROW_LEN - 1);
    drain();
    check_output("t5_det_count", 64'(det_cnt), 64'd38);
    check_output("t5_last_row", 64'(last_row), 64'd3);
    check_output("t5_last_col", 64'(last_col), 64'd7);
    check_output("t5_frame_done_pulses", 64'(fd_cnt), 64'd1);

    // Reset in the middle of row 2, then a clean frame.
    start_test();
    set_th(100, 200, 300, 400);
    load_thresholds();
    send_rows(1, 0, 1);
    for (int c = 0; c < 3; c++) send_beat(amp_for(1, 2, c), 1'b0);
    #3 reset_n = 1'b0;
    #1 check_all_zero("t6_in_reset");
    repeat (3) @(negedge clk_100mhz);
    #3 reset_n = 1'b1;
    @(negedge clk_100mhz);
    start_test();
    set_th(40, 40, 40, 40);
    load_thresholds();
    send_rows(1, 0, NUM_ROWS - 1);
    drain();
    check_output("t6_det_count", 64'(det_cnt), 64'd32);
    check_output("t6_frame_done_pulses", 64'(fd_cnt), 64'd1);
    check_output("t6_overflow", 64'(th_overflow_o), 64'd0);
    check_output("t6_len_err", 64'(row_len_err_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
